instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/ifetch_pkg.sv | 28 ++
 rtl/ifetch_if.sv | 33 +++
 rtl/instr_field_decoder.sv | 19 +
 rtl/instr_fetch.sv | 91 +++++++++
 tb/tb_instr_fetch.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding,
// instruction field positions, the HALT opcode and the default reset PC.
package ifetch_pkg;

  typedef enum logic [2:0] {
    RST_IDLE = 3'd0,
    FETCH    = 3'd1,
    WAIT     = 3'd2,
    ISSUE    = 3'd3,
    HALTED   = 3'd4
  } fetch_state_t;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;

  localparam int OPC_MSB  = 31;
  localparam int OPC_LSB  = 26;
  localparam int RS_MSB   = 25;
  localparam int RS_LSB   = 21;
  localparam int RT_MSB   = 20;
  localparam int RT_LSB   = 16;
  localparam int RD_MSB   = 15;
  localparam int RD_LSB   = 11;
  localparam int IMM1_MSB = 15;
  localparam int IMM2_MSB = 25;

  localparam logic [5:0] OPC_HALT = 6'h3F;

endpackage

// File: rtl/ifetch_if.sv
// Bus between the fetch stage, its instruction memory and the execute stage.
// Handshake: the fetch side holds instr_valid and every decoded field stable
// until the cycle in which instr_ready is also high; that cycle is the transfer.
interface ifetch_if #(
  parameter int IMEM_AW = 8
);
  logic               imem_en;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_rdata;
  logic               instr_valid;
  logic               instr_ready;
  logic [31:0]        redirect_pc;
  logic [5:0]         opcode;
  logic [4:0]         rs_addr;
  logic [4:0]         rt_addr;
  logic [4:0]         rd_addr;
  logic [15:0]        immediate_1;
  logic [25:0]        immediate_2;
  logic [31:0]        pc_next;
  logic               halted;

  modport master (
    output imem_en, imem_addr, instr_valid, opcode, rs_addr, rt_addr, rd_addr,
           immediate_1, immediate_2, pc_next, halted,
    input  imem_rdata, instr_ready, redirect_pc
  );

  modport slave (
    input  imem_en, imem_addr, instr_valid, opcode, rs_addr, rt_addr, rd_addr,
           immediate_1, immediate_2, pc_next, halted,
    output imem_rdata, instr_ready, redirect_pc
  );
endinterface

// File: rtl/instr_field_decoder.sv
// Purely combinational split of the instruction register into its fields.
module instr_field_decoder
  import ifetch_pkg::*;
(
  input  logic [31:0] i_ir,
  output logic [5:0]  o_opcode,
  output logic [4:0]  o_rs_addr,
  output logic [4:0]  o_rt_addr,
  output logic [4:0]  o_rd_addr,
  output logic [15:0] o_immediate_1,
  output logic [25:0] o_immediate_2
);
  assign o_opcode      = i_ir[OPC_MSB:OPC_LSB];
  assign o_rs_addr     = i_ir[RS_MSB:RS_LSB];
  assign o_rt_addr     = i_ir[RT_MSB:RT_LSB];
  assign o_rd_addr     = i_ir[RD_MSB:RD_LSB];
  assign o_immediate_1 = i_ir[IMM1_MSB:0];
  assign o_immediate_2 = i_ir[IMM2_MSB:0];
endmodule

// File: rtl/instr_fetch.sv
// Three-cycle instruction fetch stage (FETCH -> WAIT -> ISSUE) with PC and IR.
// Define IFETCH_HALT_EN to stop fetching after a consumed HALT opcode.
module instr_fetch
  import ifetch_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
  parameter int          IMEM_AW  = 8
) (
  input  logic         clk,
  input  logic         rst,
  ifetch_if.master     bus,
  output fetch_state_t o_dbg_state
);
  fetch_state_t r_state;
  fetch_state_t w_state_nxt;
  logic [31:0]  r_pc;
  logic [31:0]  r_ir;
  logic [5:0]   w_opcode;
  logic         w_handshake;
  logic         w_is_halt;
  logic         w_imem_en;
  logic         w_instr_valid;
  logic         w_halted;

  instr_field_decoder u_decoder (
    .i_ir          (r_ir),
    .o_opcode      (w_opcode),
    .o_rs_addr     (bus.rs_addr),
    .o_rt_addr     (bus.rt_addr),
    .o_rd_addr     (bus.rd_addr),
    .o_immediate_1 (bus.immediate_1),
    .o_immediate_2 (bus.immediate_2)
  );

  assign w_handshake = (r_state == ISSUE) && bus.instr_ready;
`ifdef IFETCH_HALT_EN
  assign w_is_halt = (w_opcode == OPC_HALT);
`else
  assign w_is_halt = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= RST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RST_IDLE: w_state_nxt = FETCH;
      FETCH:    w_state_nxt = WAIT;
      WAIT:     w_state_nxt = ISSUE;
      ISSUE:    if (bus.instr_ready) w_state_nxt = w_is_halt ? HALTED : FETCH;
      HALTED:   w_state_nxt = HALTED;
      default:  w_state_nxt = RST_IDLE;
    endcase
  end

  always_comb begin
    w_imem_en     = 1'b0;
    w_instr_valid = 1'b0;
    w_halted      = 1'b0;
    case (r_state)
      FETCH:   w_imem_en     = 1'b1;
      ISSUE:   w_instr_valid = 1'b1;
`ifdef IFETCH_HALT_EN
      HALTED:  w_halted      = 1'b1;
`endif
      default: ;
    endcase
  end

  // A HALT handshake leaves the PC pointing at the HALT instruction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc <= PC_RESET;
      r_ir <= '0;
    end else begin
      if (r_state == WAIT) r_ir <= bus.imem_rdata;
      if (w_handshake && !w_is_halt) r_pc <= bus.redirect_pc;
    end
  end

  assign bus.imem_en     = w_imem_en;
  assign bus.imem_addr   = r_pc[IMEM_AW-1:0];
  assign bus.instr_valid = w_instr_valid;
  assign bus.opcode      = w_opcode;
  assign bus.pc_next     = r_pc + 32'd1;
  assign bus.halted      = w_halted;
  assign o_dbg_state     = r_state;
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a registered-read instruction memory model.
module tb_instr_fetch;
  import ifetch_pkg::*;

  logic         clk;
  logic         rst;
  fetch_state_t dbg_state;
  logic [31:0]  mem [0:255];
  int           checks;
  int           errors;

  ifetch_if #(.IMEM_AW(8)) bus ();

  instr_fetch #(.PC_RESET(32'h0000_0000), .IMEM_AW(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory returns data one cycle after imem_en
  always @(posedge clk) begin
    if (bus.imem_en) bus.imem_rdata <= mem[bus.imem_addr];
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.instr_ready = 1'b0;
    bus.redirect_pc = 32'h0;
    step();
    checks++; if (dbg_state !== RST_IDLE) begin errors++; $display("FAIL reset_state: got %0d exp %0d", dbg_state, RST_IDLE); end
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", bus.instr_valid); end
    checks++; if (bus.imem_en !== 1'b0) begin errors++; $display("FAIL reset_imem_en: got %b exp 0", bus.imem_en); end
    checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b exp 0", bus.halted); end
    checks++; if (bus.opcode !== 6'h00 || bus.immediate_2 !== 26'h0) begin errors++; $display("FAIL reset_fields: got %h/%h exp 0/0", bus.opcode, bus.immediate_2); end
    checks++; if (bus.pc_next !== 32'h1) begin errors++; $display("FAIL reset_pc_next: got %h exp 00000001", bus.pc_next); end
  endtask

  task automatic test_first_fetch();
    rst = 1'b1;
    #1;
    checks++; if (bus.imem_en !== 1'b0) begin errors++; $display("FAIL idle_imem_en: got %b exp 0", bus.imem_en); end
    // ready/redirect driven outside ISSUE must have no effect
    bus.instr_ready = 1'b1;
    bus.redirect_pc = 32'h55;
    step();
    checks++; if (bus.imem_en !== 1'b1 || bus.imem_addr !== 8'h00) begin errors++; $display("FAIL first_fetch: got en=%b addr=%h exp en=1 addr=00", bus.imem_en, bus.imem_addr); end
    step();
    checks++; if (bus.imem_en !== 1'b0 || bus.instr_valid !== 1'b0) begin errors++; $display("FAIL first_wait: got en=%b valid=%b exp 0/0", bus.imem_en, bus.instr_valid); end
    step();
    bus.instr_ready = 1'b0;
    checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL first_valid: got %b exp 1", bus.instr_valid); end
    checks++; if (bus.opcode !== 6'h08 || bus.rs_addr !== 5'd1 || bus.rt_addr !== 5'd2 || bus.immediate_1 !== 16'h0005) begin
      errors++; $display("FAIL first_fields: got op=%h rs=%0d rt=%0d imm=%h exp op=08 rs=1 rt=2 imm=0005", bus.opcode, bus.rs_addr, bus.rt_addr, bus.immediate_1); end
    checks++; if (bus.pc_next !== 32'h1) begin errors++; $display("FAIL first_pc_next: got %h exp 00000001", bus.pc_next); end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (bus.instr_valid !== 1'b1 || bus.imem_en !== 1'b0 || bus.opcode !== 6'h08 || bus.immediate_1 !== 16'h0005 || bus.pc_next !== 32'h1) begin
        errors++; $display("FAIL stall_hold[%0d]: got valid=%b en=%b op=%h imm=%h pcn=%h exp 1/0/08/0005/00000001", i, bus.instr_valid, bus.imem_en, bus.opcode, bus.immediate_1, bus.pc_next); end
    end
    bus.instr_ready = 1'b1;
    bus.redirect_pc = 32'h7;
    step();
    bus.instr_ready = 1'b0;
    checks++; if (bus.imem_en !== 1'b1 || bus.imem_addr !== 8'h07) begin errors++; $display("FAIL stall_redirect: got en=%b addr=%h exp en=1 addr=07", bus.imem_en, bus.imem_addr); end
    step();
    step();
    checks++; if (bus.opcode !== 6'h23 || bus.rs_addr !== 5'd4 || bus.rt_addr !== 5'd3 || bus.rd_addr !== 5'd0 || bus.immediate_2 !== 26'h08300FF) begin
      errors++; $display("FAIL stall_fields: got op=%h rs=%0d rt=%0d rd=%0d imm2=%h exp 23/4/3/0/08300ff", bus.opcode, bus.rs_addr, bus.rt_addr, bus.rd_addr, bus.immediate_2); end
    checks++; if (bus.pc_next !== 32'h8) begin errors++; $display("FAIL stall_pc_next: got %h exp 00000008", bus.pc_next); end
  endtask

  task automatic test_addr_wrap();
    bus.instr_ready = 1'b1;
    bus.redirect_pc = 32'h0000_0105;
    step();
    bus.instr_ready = 1'b0;
    checks++; if (bus.imem_addr !== 8'h05 || bus.pc_next !== 32'h0000_0106) begin errors++; $display("FAIL wrap_addr: got addr=%h pcn=%h exp 05/00000106", bus.imem_addr, bus.pc_next); end
    step();
    step();
    checks++; if (bus.instr_valid !== 1'b1 || bus.rd_addr !== 5'd3 || bus.pc_next !== 32'h0000_0106) begin
      errors++; $display("FAIL wrap_issue: got valid=%b rd=%0d pcn=%h exp 1/3/00000106", bus.instr_valid, bus.rd_addr, bus.pc_next); end
  endtask

  task automatic test_back_to_back();
    int n_valid;
    int n_en;
    n_valid = 0;
    n_en = 0;
    bus.instr_ready = 1'b1;
    bus.redirect_pc = 32'h20;
    for (int i = 0; i < 9; i++) begin
      step();
      if (bus.instr_valid === 1'b1) n_valid++;
      if (bus.imem_en === 1'b1) n_en++;
    end
    bus.instr_ready = 1'b0;
    checks++; if (n_valid !== 3) begin errors++; $display("FAIL b2b_valid_count: got %0d exp 3", n_valid); end
    checks++; if (n_en !== 3) begin errors++; $display("FAIL b2b_fetch_count: got %0d exp 3", n_en); end
    checks++; if (bus.instr_valid !== 1'b1 || bus.immediate_1 !== 16'hBEEF) begin errors++; $display("FAIL b2b_last: got valid=%b imm=%h exp 1/beef", bus.instr_valid, bus.immediate_1); end
  endtask

  task automatic test_pc_wrap();
    bus.instr_ready = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFF;
    step();
    bus.instr_ready = 1'b0;
    checks++; if (bus.imem_addr !== 8'hFF || bus.pc_next !== 32'h0000_0000) begin errors++; $display("FAIL pc_wrap: got addr=%h pcn=%h exp ff/00000000", bus.imem_addr, bus.pc_next); end
    step();
    step();
  endtask

  task automatic test_reset_mid_wait();
    bus.instr_ready = 1'b1;
    bus.redirect_pc = 32'h33;
    step();
    bus.instr_ready = 1'b0;
    step();
    checks++; if (dbg_state !== WAIT) begin errors++; $display("FAIL mid_wait_state: got %0d exp %0d", dbg_state, WAIT); end
    rst = 1'b0;
    #1;
    checks++; if (dbg_state !== RST_IDLE || bus.instr_valid !== 1'b0 || bus.imem_en !== 1'b0 || bus.pc_next !== 32'h1) begin
      errors++; $display("FAIL mid_wait_reset: got st=%0d valid=%b en=%b pcn=%h exp 0/0/0/00000001", dbg_state, bus.instr_valid, bus.imem_en, bus.pc_next); end
    step();
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL mid_wait_valid: got %b exp 0", bus.instr_valid); end
    rst = 1'b1;
    step();
    checks++; if (bus.imem_en !== 1'b1 || bus.imem_addr !== 8'h00) begin errors++; $display("FAIL mid_wait_refetch: got en=%b addr=%h exp 1/00", bus.imem_en, bus.imem_addr); end
    step();
    step();
    checks++; if (bus.instr_valid !== 1'b1 || bus.opcode !== 6'h08) begin errors++; $display("FAIL mid_wait_issue: got valid=%b op=%h exp 1/08", bus.instr_valid, bus.opcode); end
  endtask

  task automatic test_halt();
    int n_en;
    n_en = 0;
    bus.instr_ready = 1'b1;
    bus.redirect_pc = 32'h9;
    step();
    bus.instr_ready = 1'b0;
    step();
    step();
    checks++; if (bus.opcode !== 6'h3F) begin errors++; $display("FAIL halt_opcode: got %h exp 3f", bus.opcode); end
    bus.instr_ready = 1'b1;
    bus.redirect_pc = 32'h44;
    step();
    bus.instr_ready = 1'b0;
`ifdef IFETCH_HALT_EN
    checks++; if (bus.halted !== 1'b1 || bus.instr_valid !== 1'b0 || bus.imem_en !== 1'b0) begin
      errors++; $display("FAIL halt_enter: got halted=%b valid=%b en=%b exp 1/0/0", bus.halted, bus.instr_valid, bus.imem_en); end
    checks++; if (bus.imem_addr !== 8'h09) begin errors++; $display("FAIL halt_pc_kept: got %h exp 09", bus.imem_addr); end
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.imem_en === 1'b1 || bus.halted !== 1'b1) n_en++;
    end
    bus.instr_ready = 1'b0;
    checks++; if (n_en !== 0) begin errors++; $display("FAIL halt_persist: got %0d bad cycles exp 0", n_en); end
    rst = 1'b0;
    #1;
    checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL halt_reset: got %b exp 0", bus.halted); end
    step();
    rst = 1'b1;
`else
    checks++; if (bus.halted !== 1'b0 || bus.imem_en !== 1'b1 || bus.imem_addr !== 8'h44) begin
      errors++; $display("FAIL halt_ignored: got halted=%b en=%b addr=%h exp 0/1/44", bus.halted, bus.imem_en, bus.imem_addr); end
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.halted !== 1'b0) n_en++;
    end
    checks++; if (n_en !== 0) begin errors++; $display("FAIL halt_never: got %0d halted cycles exp 0", n_en); end
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h00] = 32'h2022_0005;
    mem[8'h07] = 32'h8C83_00FF;
    mem[8'h05] = 32'h0000_1800;
    mem[8'h20] = 32'h0411_BEEF;
    mem[8'h09] = 32'hFC00_0000;
    mem[8'h44] = 32'h0000_0001;
    bus.imem_rdata = 32'h0;
    test_reset();
    test_first_fetch();
    test_stall();
    test_addr_wrap();
    test_back_to_back();
    test_pc_wrap();
    test_reset_mid_wait();
    test_halt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
